// File: rtl/pipeline_hazard_sequencer.sv
// pipeline_hazard_sequencer
//
// Central stall/flush sequencer for a 5-stage pipeline (IF, DEC, EX, ME, WB).
// It drives the PC write enable and the write enables and flushes of the
// IF/DEC, DEC/EX, EX/ME and ME/WB pipeline registers. It handles three cases:
//   - load-use hazards: DEC reads a register that the load in EX is writing;
//   - branch mispredict recovery: the branch is resolved in EX;
//   - multi-cycle memory-mapped IO accesses held in ME.
//
// All enables and flushes are combinational from the FSM state and the
// current inputs, so a stall takes effect in the same cycle it is detected.
//
// Optional feature: define HAZARD_PERF_CNT_EN to build the saturating stall
// and flush performance counters. When the macro is not defined, stall_cnt
// and flush_cnt are tied to zero and no counter flops are built.
//
// Ports
//   clk          in   1     system clock
//   reset        in   1     synchronous, active-high reset
//   dec_rs1      in   RIW   rs1 index of the instruction in DEC
//   dec_rs2      in   RIW   rs2 index of the instruction in DEC
//   dec_use_rs1  in   1     the DEC instruction reads rs1
//   dec_use_rs2  in   1     the DEC instruction reads rs2
//   ex_rd        in   RIW   destination index of the instruction in EX
//   ex_is_load   in   1     the EX instruction is a load that writes ex_rd
//   mispredict   in   1     the branch in EX resolved against its prediction
//   io_req       in   1     the ME instruction is an IO access
//   pc_wr_en     out  1     PC write enable
//   if_wr_en     out  1     IF/DEC register write enable
//   dec_wr_en    out  1     DEC/EX register write enable
//   ex_wr_en     out  1     EX/ME register write enable
//   me_wr_en     out  1     ME/WB register write enable
//   if_flush     out  1     load a NOP into the IF/DEC register
//   dec_flush    out  1     load a bubble into the DEC/EX register
//   stall_cnt    out  CNT   stall cycles (PC held), when the counters are built
//   flush_cnt    out  CNT   mispredict flush events, when the counters are built
module pipeline_hazard_sequencer #(
  parameter int REG_INDEX_BIT_WIDTH = 4,
  parameter int IO_WAIT_CYCLES      = 3,
  parameter int CNT_BITS            = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] dec_rs1,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] dec_rs2,
  input  logic                           dec_use_rs1,
  input  logic                           dec_use_rs2,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] ex_rd,
  input  logic                           ex_is_load,
  input  logic                           mispredict,
  input  logic                           io_req,
  output logic                           pc_wr_en,
  output logic                           if_wr_en,
  output logic                           dec_wr_en,
  output logic                           ex_wr_en,
  output logic                           me_wr_en,
  output logic                           if_flush,
  output logic                           dec_flush,
  output logic [CNT_BITS-1:0]            stall_cnt,
  output logic [CNT_BITS-1:0]            flush_cnt
);

  // The wait counter only has to hold IO_WAIT_CYCLES-1.
  localparam int CW = (IO_WAIT_CYCLES > 1) ? $clog2(IO_WAIT_CYCLES) : 1;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    IO_WAIT    = 2'd1,
    IO_RELEASE = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic          load_use;

  // Register index 0 is compared like any other register.
  assign load_use = ex_is_load &
                    ((dec_use_rs1 & (dec_rs1 == ex_rd)) |
                     (dec_use_rs2 & (dec_rs2 == ex_rd)));

  // The cycle that first sees io_req in RUN is freeze cycle 1; IO_WAIT then
  // supplies the remaining IO_WAIT_CYCLES-1 frozen cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      unique case (state)
        RUN: begin
          if (io_req) begin
            wait_cnt <= CW'(IO_WAIT_CYCLES - 1);
            state    <= (IO_WAIT_CYCLES == 1) ? IO_RELEASE : IO_WAIT;
          end
        end
        IO_WAIT: begin
          wait_cnt <= wait_cnt - CW'(1);
          if (wait_cnt == CW'(1)) state <= IO_RELEASE;
        end
        IO_RELEASE: state <= RUN;
        default:    state <= RUN;
      endcase
    end
  end

  // Freeze has priority over everything and never coexists with a flush.
  // IO_RELEASE ignores io_req so the access just served does not retrigger.
  always_comb begin
    pc_wr_en  = 1'b1;
    if_wr_en  = 1'b1;
    dec_wr_en = 1'b1;
    ex_wr_en  = 1'b1;
    me_wr_en  = 1'b1;
    if_flush  = 1'b0;
    dec_flush = 1'b0;
    if (!reset) begin
      if ((state == IO_WAIT) || ((state == RUN) && io_req)) begin
        pc_wr_en  = 1'b0;
        if_wr_en  = 1'b0;
        dec_wr_en = 1'b0;
        ex_wr_en  = 1'b0;
        me_wr_en  = 1'b0;
      end else if (mispredict) begin
        if_flush  = 1'b1;
        dec_flush = 1'b1;
      end else if (load_use) begin
        // DEC/EX stays enabled so the bubble is actually written into it.
        pc_wr_en  = 1'b0;
        if_wr_en  = 1'b0;
        dec_flush = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
    return (&v) ? v : v + CNT_BITS'(1);
  endfunction

  logic [CNT_BITS-1:0] stall_q;
  logic [CNT_BITS-1:0] flush_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_wr_en) stall_q <= sat_inc(stall_q);
      if (if_flush)  flush_q <= sat_inc(flush_q);
    end
  end

  // Counters read as zero for the whole time reset is high.
  assign stall_cnt = reset ? '0 : stall_q;
  assign flush_cnt = reset ? '0 : flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
// Testbench for pipeline_hazard_sequencer: directed scenarios followed by
// randomized traffic, every cycle compared against a cycle-level model of the
// sequencing rules (freeze length, release cycle, flush/stall priorities).
module tb_pipeline_hazard_sequencer;

  localparam int RIW = 4;
  localparam int N   = 3;
  localparam int CB  = 16;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic [RIW-1:0] dec_rs1, dec_rs2, ex_rd;
  logic           dec_use_rs1, dec_use_rs2, ex_is_load, mispredict, io_req;
  logic           pc_wr_en, if_wr_en, dec_wr_en, ex_wr_en, me_wr_en;
  logic           if_flush, dec_flush;
  logic [CB-1:0]  stall_cnt, flush_cnt;

  pipeline_hazard_sequencer #(
    .REG_INDEX_BIT_WIDTH(RIW),
    .IO_WAIT_CYCLES(N),
    .CNT_BITS(CB)
  ) dut (
    .clk(clk), .reset(reset),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load),
    .mispredict(mispredict), .io_req(io_req),
    .pc_wr_en(pc_wr_en), .if_wr_en(if_wr_en), .dec_wr_en(dec_wr_en),
    .ex_wr_en(ex_wr_en), .me_wr_en(me_wr_en),
    .if_flush(if_flush), .dec_flush(dec_flush),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: frozen cycles still owed, and whether the next
  // unfrozen cycle is the release cycle that must ignore io_req.
  int frz_left  = 0;
  bit release_c = 1'b0;
  int m_stall   = 0;
  int m_flush   = 0;
  int max_cnt   = (1 << CB) - 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one cycle of inputs (just after a rising edge), check outputs at the
  // falling edge, then advance the model across the next rising edge.
  task automatic step(input bit r, input logic [RIW-1:0] s1, input logic [RIW-1:0] s2,
                      input bit u1, input bit u2, input logic [RIW-1:0] rd,
                      input bit ld, input bit mp, input bit io, input string tag);
    logic [6:0] exp_v;
    logic [6:0] obs_v;
    bit lu;
    reset = r; dec_rs1 = s1; dec_rs2 = s2; dec_use_rs1 = u1; dec_use_rs2 = u2;
    ex_rd = rd; ex_is_load = ld; mispredict = mp; io_req = io;
    #4;
    lu = ld && ((u1 && s1 == rd) || (u2 && s2 == rd));
    // bit order: pc, if, dec, ex, me, if_flush, dec_flush
    if (r)                          exp_v = 7'b11111_00;
    else if (frz_left > 0)          exp_v = 7'b00000_00;
    else if (!release_c && io)      exp_v = 7'b00000_00;
    else if (mp)                    exp_v = 7'b11111_11;
    else if (lu)                    exp_v = 7'b00111_01;
    else                            exp_v = 7'b11111_00;
    obs_v = {pc_wr_en, if_wr_en, dec_wr_en, ex_wr_en, me_wr_en, if_flush, dec_flush};
    check({tag, ".en"}, 32'(obs_v), 32'(exp_v));
    check({tag, ".stall_cnt"}, 32'(stall_cnt), (PERF && !r) ? 32'(m_stall) : 32'd0);
    check({tag, ".flush_cnt"}, 32'(flush_cnt), (PERF && !r) ? 32'(m_flush) : 32'd0);
    if (r) begin
      frz_left = 0; release_c = 1'b0; m_stall = 0; m_flush = 0;
    end else begin
      if (!exp_v[6] && m_stall < max_cnt) m_stall++;
      if (exp_v[1] && m_flush < max_cnt)  m_flush++;
      if (frz_left > 0) begin
        frz_left--;
        if (frz_left == 0) release_c = 1'b1;
      end else if (!release_c && io) begin
        frz_left  = N - 1;
        release_c = (N == 1);
      end else begin
        release_c = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string tag);
    step(0, 4'd1, 4'd2, 0, 0, 4'd3, 0, 0, 0, tag);
  endtask

  initial begin
    reset = 1'b1; dec_rs1 = '0; dec_rs2 = '0; ex_rd = '0;
    dec_use_rs1 = 0; dec_use_rs2 = 0; ex_is_load = 0; mispredict = 0; io_req = 0;
    @(posedge clk);
    #1;
    step(1, 4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 0, "reset");
    step(1, 4'd5, 4'd5, 1, 1, 4'd5, 1, 1, 1, "reset_busy_inputs");
    idle("run_idle");
    // load-use on rs1, then hazard gone
    step(0, 4'd5, 4'd7, 1, 0, 4'd5, 1, 0, 0, "t1_loaduse");
    step(0, 4'd5, 4'd7, 1, 0, 4'd5, 0, 0, 0, "t1_after");
    // same indices, no register read
    step(0, 4'd5, 4'd5, 0, 0, 4'd5, 1, 0, 0, "t2_nouse");
    // rs2 hazard on register 0
    step(0, 4'd3, 4'd0, 1, 1, 4'd0, 1, 0, 0, "loaduse_rs2_r0");
    // mispredict in RUN, beats a load-use
    step(0, 4'd5, 4'd5, 1, 1, 4'd5, 1, 1, 0, "t3_mispredict");
    idle("t3_after");
    // io_req held high: freeze N, release 1, freeze again
    for (int i = 0; i < 2 * (N + 1) + 1; i++) step(0, 4'd1, 4'd2, 0, 0, 4'd3, 0, 0, 1, "t4_io_held");
    idle("t4_drain");
    for (int i = 0; i < N + 1; i++) idle("t4_drain2");
    // io_req with mispredict: freeze first, flush on release
    step(0, 4'd1, 4'd2, 0, 0, 4'd3, 0, 1, 1, "t5_io_mp");
    for (int i = 0; i < N; i++) step(0, 4'd1, 4'd2, 0, 0, 4'd3, 0, 1, 0, "t5_wait_release");
    idle("t5_after");
    // reset during IO_WAIT cycle 2
    step(0, 4'd1, 4'd2, 0, 0, 4'd3, 0, 0, 1, "t6_io");
    step(0, 4'd1, 4'd2, 0, 0, 4'd3, 0, 0, 0, "t6_wait1");
    step(1, 4'd1, 4'd2, 0, 0, 4'd3, 0, 0, 0, "t6_reset");
    step(0, 4'd4, 4'd4, 1, 0, 4'd4, 1, 0, 0, "t6_run_loaduse");
    idle("t6_idle");
    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 59) == 0),
           RIW'($urandom_range(0, 3)), RIW'($urandom_range(0, 3)),
           bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
           RIW'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0), "rand");
    end
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
